// File: rtl/speed_meter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | speed_meter: wheel speed from reed period via a shared divider   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module speed_meter #(
  parameter int               WIDTH       = 16,
  parameter int               WIDTH_SPEED = 12,
  parameter logic [WIDTH-1:0] CONST       = 16'h49BA,
  parameter int               MAX_SPEED   = 99,
  parameter int               AVG_LOG2    = 2,
  parameter logic [WIDTH-1:0] TIMEOUT     = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   reed,
  input  logic [7:0]             circ,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic                   clr_max,
  output logic [WIDTH_SPEED-1:0] speed,
  output logic                   valid,
  output logic [WIDTH-1:0]       dividend,
  output logic [WIDTH-1:0]       divisor,
  output logic                   div_req,
  input  logic                   Busy,
  input  logic                   Ready,
  input  logic [WIDTH-1:0]       dividerres
);

  localparam int                     DEPTH = 1 << AVG_LOG2;
  localparam int                     SW    = WIDTH_SPEED + AVG_LOG2;
  localparam logic [WIDTH-1:0]       MAX_W = WIDTH'(MAX_SPEED);
  localparam logic [WIDTH_SPEED-1:0] MAX_S = WIDTH_SPEED'(MAX_SPEED);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FREE  = 3'd1,
    WAIT_BUSY  = 3'd2,
    WAIT_READY = 3'd3,
    UPDATE     = 3'd4
  } state_t;

  state_t                 state_q;
  logic                   reed_q;
  logic [WIDTH-1:0]       cnt_q, cnt_d, tim_q;
  logic                   stopped_q, stopped_d;
  logic [1:0]             mode_q;
  logic [WIDTH_SPEED-1:0] sample_q, max_q, max_d, speed_q, speed_d;
  logic [WIDTH_SPEED-1:0] buf_q [DEPTH];
  logic [AVG_LOG2-1:0]    wptr_q;
  logic [SW-1:0]          sum_q, sum_d;
  logic                   valid_q, div_req_q;
  logic [WIDTH-1:0]       dividend_q, divisor_q;
  logic                   w_reed_evt;
  logic [WIDTH+7:0]       w_prod;
  logic [WIDTH_SPEED-1:0] w_sat;

  assign w_reed_evt = reed & ~reed_q;
  assign w_prod     = {{WIDTH{1'b0}}, circ} * {8'd0, CONST};
  assign w_sat      = (dividerres > MAX_W) ? MAX_S : dividerres[WIDTH_SPEED-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (w_reed_evt)
      cnt_d = '0;
    else if (en && cnt_q != TIMEOUT)
      cnt_d = cnt_q + 1'b1;
    // A reed event zeroes cnt_d, so it also keeps stopped clear.
    stopped_d = w_reed_evt ? 1'b0 : (stopped_q | (cnt_d == TIMEOUT));

    sum_d = sum_q - SW'(buf_q[wptr_q]) + SW'(sample_q);
    max_d = max_q;
    if (clr_max)
      max_d = '0;
    else if (state_q == UPDATE && sample_q > max_q)
      max_d = sample_q;

    case (mode_q)
      2'd1:    speed_d = sum_d[SW-1:AVG_LOG2];
      2'd2:    speed_d = max_d;
      default: speed_d = sample_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      reed_q     <= 1'b0;
      cnt_q      <= '0;
      tim_q      <= '0;
      stopped_q  <= 1'b0;
      mode_q     <= '0;
      sample_q   <= '0;
      max_q      <= '0;
      speed_q    <= '0;
      wptr_q     <= '0;
      sum_q      <= '0;
      valid_q    <= 1'b0;
      div_req_q  <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      reed_q    <= reed;
      cnt_q     <= cnt_d;
      stopped_q <= stopped_d;
      max_q     <= max_d;
      div_req_q <= 1'b0;
      if (w_reed_evt) tim_q <= cnt_q;

      case (state_q)
        IDLE: begin
          if (start) begin
            valid_q <= 1'b0;
            mode_q  <= mode;
            state_q <= WAIT_FREE;
          end
        end
        WAIT_FREE: begin
          if (stopped_q || tim_q == '0) begin
            sample_q <= '0;
            state_q  <= UPDATE;
          end else if (!Busy) begin
            dividend_q <= w_prod[WIDTH+7:8];
            divisor_q  <= tim_q;
            div_req_q  <= 1'b1;
            state_q    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (Busy) state_q <= WAIT_READY;
        end
        WAIT_READY: begin
          if (Ready) begin
            sample_q <= w_sat;
            state_q  <= UPDATE;
          end
        end
        UPDATE: begin
          buf_q[wptr_q] <= sample_q;
          wptr_q        <= wptr_q + 1'b1;
          sum_q         <= sum_d;
          speed_q       <= speed_d;
          valid_q       <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign speed    = speed_q;
  assign valid    = valid_q;
  assign dividend = dividend_q;
  assign divisor  = divisor_q;
  assign div_req  = div_req_q;

endmodule
`default_nettype wire

// File: tb/tb_speed_meter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_speed_meter: table-driven bench with divider model            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_speed_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, reed = 1'b0, start = 1'b0, clr_max = 1'b0;
  logic        Busy = 1'b0, Ready = 1'b0;
  logic [7:0]  circ = 8'd200;
  logic [1:0]  mode = 2'd0;
  logic [15:0] dividerres = 16'd0;
  logic [11:0] speed;
  logic        valid, div_req;
  logic [15:0] dividend, divisor;

  int n_chk = 0;
  int n_err = 0;
  int sb[$];

  typedef struct {
    bit     pre_rst;
    bit     pre_clr;
    bit [1:0] m;
    int     q;
    int     exp_speed;
  } vec_t;
  vec_t tbl[12];

  speed_meter #(.TIMEOUT(16'd2000)) dut (
    .clk(clk), .rst(rst), .en(en), .reed(reed), .circ(circ),
    .start(start), .mode(mode), .clr_max(clr_max),
    .speed(speed), .valid(valid), .dividend(dividend), .divisor(divisor),
    .div_req(div_req), .Busy(Busy), .Ready(Ready), .dividerres(dividerres)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; en = 1'b0; reed = 1'b0;
    Busy = 1'b0; Ready = 1'b0; clr_max = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // n en-ticks, then a reed rising edge with en low: tim becomes n.
  task automatic wheel(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b1;
    end
    @(negedge clk);
    en = 1'b0; reed = 1'b1;
    @(negedge clk);
    reed = 1'b0;
  endtask

  task automatic start_update(input bit [1:0] m, input int exp_speed);
    @(negedge clk);
    start = 1'b1; mode = m;
    sb.push_back(exp_speed);
    @(negedge clk);
    start = 1'b0;
    check("valid_cleared", int'(valid), 0);
  endtask

  // Divider model plus completion wait; the speed is popped from the scoreboard.
  task automatic finish_update(input int q, input bit expect_div,
                               input int exp_dvd, input int exp_dvs, input bit chk_lat);
    int lat = 1;
    bit got_div = 1'b0;
    bit done = 1'b0;
    int exp;
    while (!done && lat < 200) begin
      if (valid) done = 1'b1;
      else if (div_req) begin
        got_div = 1'b1;
        check("dividend", int'(dividend), exp_dvd);
        check("divisor", int'(divisor), exp_dvs);
        Busy = 1'b1;
        @(negedge clk); lat++;
        check("div_req_one_pulse", int'(div_req), 0);
        Busy = 1'b0; Ready = 1'b1; dividerres = 16'(q);
        @(negedge clk); lat++;
        Ready = 1'b0;
      end else begin
        @(negedge clk); lat++;
      end
    end
    check("div_used", int'(got_div), int'(expect_div));
    check("valid_seen", int'(done), 1);
    if (done && sb.size() > 0) begin
      exp = sb.pop_front();
      check("speed", int'(speed), exp);
      if (chk_lat) check("latency", lat, 3);
    end
  endtask

  task automatic run_update(input bit [1:0] m, input int q, input bit expect_div,
                            input int exp_dvd, input int exp_dvs, input int exp_speed);
    start_update(m, exp_speed);
    finish_update(q, expect_div, exp_dvd, exp_dvs, !expect_div);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 14,    14};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, 150,   99};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 4096,  99};
    tbl[3]  = '{1'b1, 1'b0, 2'd1, 10,    2};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 20,    7};
    tbl[5]  = '{1'b0, 1'b0, 2'd1, 30,    15};
    tbl[6]  = '{1'b0, 1'b0, 2'd1, 40,    25};
    tbl[7]  = '{1'b0, 1'b0, 2'd1, 50,    35};
    tbl[8]  = '{1'b0, 1'b0, 2'd2, 20,    50};
    tbl[9]  = '{1'b0, 1'b0, 2'd3, 7,     7};
    tbl[10] = '{1'b0, 1'b1, 2'd2, 5,     5};
    tbl[11] = '{1'b0, 1'b0, 2'd1, 0,     8};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_speed", int'(speed), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_div_req", int'(div_req), 0);
    check("rst_dividend", int'(dividend), 0);
    check("rst_divisor", int'(divisor), 0);
    rst = 1'b0;

    // tim=0 right after reset: zero sample without the divider
    run_update(2'd0, 0, 1'b0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].pre_rst) begin
        do_reset();
        wheel(1000);
      end
      if (tbl[i].pre_clr) begin
        @(negedge clk); clr_max = 1'b1;
        @(negedge clk); clr_max = 1'b0;
      end
      run_update(tbl[i].m, tbl[i].q, 1'b1, 14745, 1000, tbl[i].exp_speed);
    end

    // Wheel stopped: no reed for TIMEOUT ticks
    repeat (2005) begin
      @(negedge clk);
      en = 1'b1;
    end
    @(negedge clk);
    en = 1'b0;
    run_update(2'd0, 77, 1'b0, 0, 0, 0);
    check("dividend_hold", int'(dividend), 14745);
    check("divisor_hold", int'(divisor), 1000);

    // Divider busy for 20 cycles; a second start is ignored
    do_reset();
    wheel(1000);
    Busy = 1'b1;
    start_update(2'd0, 14);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 8) begin start = 1'b1; mode = 2'd1; end
      if (i == 9) start = 1'b0;
      check("busy_no_div_req", int'(div_req), 0);
      if (i % 5 == 0) check("busy_no_dividend", int'(dividend), 0);
    end
    start = 1'b0;
    Busy = 1'b0;
    finish_update(14, 1'b1, 14745, 1000, 1'b0);

    // Reset in WAIT_READY, then a stale Ready
    @(negedge clk);
    start = 1'b1; mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !div_req; i++) @(negedge clk);
    check("rr_div_req_seen", int'(div_req), 1);
    Busy = 1'b1;
    @(negedge clk);
    Busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; Ready = 1'b1; dividerres = 16'd50;
    check("rr_speed", int'(speed), 0);
    check("rr_valid", int'(valid), 0);
    check("rr_dividend", int'(dividend), 0);
    check("rr_divisor", int'(divisor), 0);
    check("rr_div_req", int'(div_req), 0);
    repeat (10) @(negedge clk);
    Ready = 1'b0;
    check("rr_stale_ready_valid", int'(valid), 0);
    check("rr_stale_ready_speed", int'(speed), 0);

    // Reed edge coincident with en: cnt restarts from 0
    repeat (500) begin
      @(negedge clk);
      en = 1'b1;
    end
    @(negedge clk);
    reed = 1'b1;
    @(negedge clk);
    reed = 1'b0; en = 1'b0;
    wheel(300);
    run_update(2'd0, 49, 1'b1, 14745, 300, 49);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
